// File: rtl/seg_pkg.sv
// Shared constants and types for the 7-segment scan controller.
// Segment vectors are active-high {a,b,c,d,e,f,g}.
package seg_pkg;

    localparam int NUM_DIGITS = 4;

    localparam logic [6:0] SEG_BLANK = 7'b000_0000;

    // Packed so entry 0 sits in the low bits; index with the hex nibble.
    localparam logic [15:0][6:0] HEX_SEG = {
        7'b100_0111,  // F
        7'b100_1111,  // E
        7'b011_1101,  // d
        7'b100_1110,  // C
        7'b001_1111,  // b
        7'b111_0111,  // A
        7'b111_1011,  // 9
        7'b111_1111,  // 8
        7'b111_0000,  // 7
        7'b101_1111,  // 6
        7'b101_1011,  // 5
        7'b011_0011,  // 4
        7'b111_1001,  // 3
        7'b110_1101,  // 2
        7'b011_0000,  // 1
        7'b111_1110   // 0
    };

    typedef enum logic [0:0] {
        BLANK = 1'b0,
        DRIVE = 1'b1
    } scan_state_e;

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// Load handshake between the data source (master) and the scan controller (slave).
interface seg_scan_ctrl_if;

    logic        load_valid;
    logic        load_ready;
    logic [15:0] load_data;

    modport master (
        output load_valid,
        output load_data,
        input  load_ready
    );

    modport slave (
        input  load_valid,
        input  load_data,
        output load_ready
    );

endinterface

// File: rtl/seg_scan_ctrl_hex_to_seg.sv
// Combinational hex nibble to 7-segment decoder driven by the shared table.
module hex_to_seg
    import seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = HEX_SEG[nibble];

endmodule

// File: rtl/seg_scan_ctrl.sv
// 4-digit multiplexed 7-segment scan controller with double-buffered load.
// Optional build macro LEADING_ZERO_BLANK_EN suppresses leading zero digits.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int TICK_DIV     = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic                  clk,
    input  logic                  rst_n,
    seg_scan_ctrl_if.slave        load,
    output logic [NUM_DIGITS-1:0] anodes,
    output logic [6:0]            segments,
    output logic [1:0]            digit_idx,
    output logic                  frame_done
);

    localparam int CW = $clog2(TICK_DIV);

    logic [CW-1:0] cnt;
    scan_state_e   state;
    logic [15:0]   display;
    logic [15:0]   pending;
    logic          pending_full;

    logic          slot_end;
    logic          boundary;
    logic          accept;
    logic [3:0]    nibble;
    logic [6:0]    dec_seg;
    logic [6:0]    drive_seg;

    assign slot_end = (cnt == CW'(TICK_DIV - 1));
    assign boundary = slot_end && (digit_idx == 2'd3);

    // The commit cycle never accepts, so pending is stable while it is copied.
    assign load.load_ready = !pending_full && !boundary;
    assign accept          = load.load_valid && load.load_ready;

    assign nibble = display[{digit_idx, 2'b00} +: 4];

    hex_to_seg u_dec (
        .nibble (nibble),
        .seg    (dec_seg)
    );

`ifdef LEADING_ZERO_BLANK_EN
    logic upper_zero;
    assign upper_zero = ((display >> {digit_idx, 2'b00}) == 16'h0000);
    assign drive_seg  = (digit_idx != 2'd0 && upper_zero) ? SEG_BLANK : dec_seg;
`else
    assign drive_seg  = dec_seg;
`endif

    // Slot timing and digit sequencing
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            digit_idx <= 2'd0;
            state     <= BLANK;
        end else begin
            if (slot_end) begin
                cnt       <= '0;
                digit_idx <= digit_idx + 2'd1;
            end else begin
                cnt <= cnt + 1'b1;
            end

            if (state == BLANK && cnt == CW'(BLANK_CYCLES - 1))
                state <= DRIVE;
            else if (slot_end)
                state <= BLANK;
        end
    end

    // Double buffer: display only changes on the frame boundary
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            display      <= 16'h0000;
            pending      <= 16'h0000;
            pending_full <= 1'b0;
        end else if (boundary && pending_full) begin
            display      <= pending;
            pending_full <= 1'b0;
        end else if (accept) begin
            pending      <= load.load_data;
            pending_full <= 1'b1;
        end
    end

    // Registered pin-facing outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            anodes     <= '0;
            segments   <= SEG_BLANK;
            frame_done <= 1'b0;
        end else begin
            anodes     <= (state == DRIVE) ? (NUM_DIGITS'(1) << digit_idx) : '0;
            segments   <= (state == DRIVE) ? drive_seg : SEG_BLANK;
            frame_done <= boundary;
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl (TICK_DIV=8, BLANK_CYCLES=2); honours LEADING_ZERO_BLANK_EN.
module tb_seg_scan_ctrl;

    localparam int TD = 8;
    localparam int BC = 2;
    localparam int FRAME = 4 * TD;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] anodes;
    logic [6:0] segments;
    logic [1:0] digit_idx;
    logic       frame_done;

    seg_scan_ctrl_if lif ();

    seg_scan_ctrl #(.TICK_DIV(TD), .BLANK_CYCLES(BC)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (lif.slave),
        .anodes     (anodes),
        .segments   (segments),
        .digit_idx  (digit_idx),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    localparam logic [6:0] DEC [16] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
        7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
        7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
        7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
    };

    typedef struct {
        string       name;
        logic [15:0] val;
        logic [27:0] segs;  // {digit3, digit2, digit1, digit0}
    } vec_t;

    int checks = 0;
    int fails  = 0;

    // Reference model: time since reset release plus the two buffered values.
    int          k;
    logic [15:0] m_disp;
    logic [15:0] m_pend;
    bit          m_full;

    function automatic logic [6:0] exp_seg(input logic [15:0] v, input int d);
        logic [15:0] up;
        up = v >> (4 * d);
`ifdef LEADING_ZERO_BLANK_EN
        if (d > 0 && up == 16'h0000) return 7'b0000000;
`endif
        return DEC[up[3:0]];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        k      = 0;
        m_disp = 16'h0000;
        m_pend = 16'h0000;
        m_full = 1'b0;
    endtask

    // One clock: called at a negedge, returns at the next negedge.
    task automatic step(input bit v, input logic [15:0] data, output bit rdy_seen);
        int c, d;
        bit bnd, rdy;
        lif.load_valid = v;
        lif.load_data  = data;
        #1;
        c   = k % TD;
        d   = (k / TD) % 4;
        bnd = (c == TD - 1) && (d == 3);
        rdy = !m_full && !bnd;
        rdy_seen = lif.load_ready;
        chk("load_ready", 32'(lif.load_ready), 32'(rdy));
        chk("digit_idx", 32'(digit_idx), 32'(d));
        @(posedge clk);
        #1;
        chk("anodes", 32'(anodes), (c >= BC) ? (32'd1 << d) : 32'd0);
        chk("segments", 32'(segments), (c >= BC) ? 32'(exp_seg(m_disp, d)) : 32'd0);
        chk("frame_done", 32'(frame_done), 32'(bnd));
        if (bnd && m_full) begin
            m_disp = m_pend;
            m_full = 1'b0;
        end
        if (v && rdy) begin
            m_pend = data;
            m_full = 1'b1;
        end
        k++;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        bit r;
        repeat (n) step(1'b0, 16'($urandom), r);
    endtask

    // Advance until the pre-edge position is (count c, digit d); at most one frame.
    task automatic step_to(input int c, input int d);
        bit r;
        for (int i = 0; i <= FRAME; i++) begin
            if (k % TD == c && (k / TD) % 4 == d) return;
            step(1'b0, 16'($urandom), r);
        end
        chk("step_to_reached", 32'(k % FRAME), 32'(d * TD + c));
    endtask

    task automatic do_reset();
        lif.load_valid = 1'b0;
        lif.load_data  = 16'h0000;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_anodes", 32'(anodes), 32'd0);
        chk("rst_segments", 32'(segments), 32'd0);
        chk("rst_frame_done", 32'(frame_done), 32'd0);
        chk("rst_digit_idx", 32'(digit_idx), 32'd0);
        chk("rst_load_ready", 32'(lif.load_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    // Load a value mid-frame, then check each driven digit of the frame that shows it.
    task automatic show_vec(input vec_t v);
        bit r;
        int c, d;
        step_to(4, 1);
        step(1'b1, v.val, r);
        chk({v.name, "_accept"}, 32'(r), 32'd1);
        step_to(0, 0);
        for (int i = 0; i < FRAME; i++) begin
            c = k % TD;
            d = (k / TD) % 4;
            step(1'b0, 16'h0000, r);
            if (c == BC + 1)
                chk({v.name, "_digit", 8'(8'h30 + d)}, 32'(segments), 32'(v.segs[7 * d +: 7]));
        end
    endtask

    vec_t vecs [$];

    initial begin
        bit r;
        int n;

        vecs.push_back('{"v1234", 16'h1234, {7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011}});
        vecs.push_back('{"v5678", 16'h5678, {7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111}});
        vecs.push_back('{"v9ABC", 16'h9ABC, {7'b1111011, 7'b1110111, 7'b0011111, 7'b1001110}});
        vecs.push_back('{"vDEF0", 16'hDEF0, {7'b0111101, 7'b1001111, 7'b1000111, 7'b1111110}});
        vecs.push_back('{"vF00D", 16'hF00D, {7'b1000111, 7'b1111110, 7'b1111110, 7'b0111101}});
`ifdef LEADING_ZERO_BLANK_EN
        vecs.push_back('{"v00A5", 16'h00A5, {7'b0000000, 7'b0000000, 7'b1110111, 7'b1011011}});
        vecs.push_back('{"v0000", 16'h0000, {7'b0000000, 7'b0000000, 7'b0000000, 7'b1111110}});
`endif

        // Free-running scan of the reset value
        do_reset();
        idle(40);

        // Load mid digit 1; shown from the next frame
        step_to(3, 1);
        step(1'b1, 16'h1234, r);
        chk("t2_accepted", 32'(r), 32'd1);
        idle(2 * FRAME);

        // Table of values
        foreach (vecs[i]) show_vec(vecs[i]);

        // Back-to-back loads: second one stalls until after the boundary
        step_to(3, 1);
        step(1'b1, 16'hAAAA, r);
        chk("t3_first_accepted", 32'(r), 32'd1);
        n = 0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            step(1'b1, 16'hBBBB, r);
            n++;
            if (r) break;
        end
        chk("t3_stall_steps", 32'(n), 32'd21);
        idle(2 * FRAME);

        // Load offered exactly in the boundary cycle with pending empty
        step_to(TD - 1, 3);
        step(1'b1, 16'h4C4C, r);
        chk("t4_boundary_ready", 32'(r), 32'd0);
        step(1'b1, 16'h4C4C, r);
        chk("t4_next_ready", 32'(r), 32'd1);
        idle(2 * FRAME);

        // Reset during DRIVE of digit 2 with pending full
        step_to(2, 0);
        step(1'b1, 16'h5A5A, r);
        step_to(BC + 2, 2);
        rst_n = 1'b0;
        #1;
        chk("t5_anodes", 32'(anodes), 32'd0);
        chk("t5_segments", 32'(segments), 32'd0);
        chk("t5_load_ready", 32'(lif.load_ready), 32'd1);
        chk("t5_digit_idx", 32'(digit_idx), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        idle(2 * FRAME);

        // Randomized loads against the model
        for (int i = 0; i < 800; i++)
            step(($urandom % 6) == 0, 16'($urandom), r);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
